// File: rtl/vote_sequencer_if.sv
// Frame-notification and slot-readout signals shared by the vote sequencer and its environment.
interface vote_sequencer_if #(
  parameter int unsigned AW = 12
);
  logic          frame_done;
  logic [1:0]    frame_id;
  logic [AW-1:0] frame_len;
  logic          vote_start;
  logic [2:0]    copy_mask;
  logic          rd_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_last;
  logic          busy;
  logic          lost;
  logic [7:0]    drop_cnt;

  modport slave (
    input  frame_done, frame_id, frame_len, rd_ready,
    output vote_start, copy_mask, rd_en, rd_addr, rd_last, busy, lost, drop_cnt
  );

  modport master (
    output frame_done, frame_id, frame_len, rd_ready,
    input  vote_start, copy_mask, rd_en, rd_addr, rd_last, busy, lost, drop_cnt
  );
endinterface

// File: rtl/vote_sequencer.sv
// Collects up to three redundant frame copies, launches a vote and streams the slot readout.
// Define VOTE_SEQ_LEN_CHECK_EN to drop groups whose present copies disagree on length.
module vote_sequencer #(
  parameter int unsigned TIMEOUT = 50000,
  parameter int unsigned AW      = 12
) (
  input logic             clk,
  input logic             rst,
  vote_sequencer_if.slave bus
);
  typedef enum logic [2:0] {StIdle, StCollect, StVote, StRead, StDrop} state_e;

  localparam logic [15:0] TimerLast = 16'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [2:0]          mask_q, mask_d, mask_acc;
  logic [15:0]         timer_q, timer_d;
  logic [2:0][AW-1:0]  len_q, len_acc;
  logic [AW-1:0]       rd_len_q, rd_len_d, rd_addr_q, rd_addr_d;
  logic                vote_start_q, rd_en_q, rd_last_q, busy_q, lost_q, lost_d;
  logic [2:0]          copy_mask_q;
  logic [7:0]          drop_cnt_q;
  logic [2:0]          id_bit;
  logic                valid_frame, dup, accept, len_mismatch;
  state_e              close_state;

  always_comb begin
    unique case (bus.frame_id)
      2'd1:    id_bit = 3'b001;
      2'd2:    id_bit = 3'b010;
      2'd3:    id_bit = 3'b100;
      default: id_bit = 3'b000;
    endcase
  end

  assign valid_frame = bus.frame_done && (bus.frame_id != 2'd0);
  assign dup         = valid_frame && (state_q == StCollect) && |(mask_q & id_bit);
  assign accept      = valid_frame && ((state_q == StIdle) || ((state_q == StCollect) && !dup));
  assign mask_acc    = accept ? (mask_q | id_bit) : mask_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      len_acc[i] = (accept && id_bit[i]) ? bus.frame_len : len_q[i];
    end
  end

`ifdef VOTE_SEQ_LEN_CHECK_EN
  always_comb begin
    len_mismatch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = i + 1; j < 3; j++) begin
        if (mask_acc[i] && mask_acc[j] && (len_acc[i] != len_acc[j])) len_mismatch = 1'b1;
      end
    end
  end
`else
  assign len_mismatch = 1'b0;
`endif

  // A duplicate id leaves mask_acc untouched, so this also covers the duplicate close.
  assign close_state = (($countones(mask_acc) >= 2) && !len_mismatch) ? StVote : StDrop;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    timer_d   = timer_q;
    rd_len_d  = rd_len_q;
    rd_addr_d = rd_addr_q;
    // Any valid frame not taken into the group is reported as lost.
    lost_d    = valid_frame && !accept;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mask_d  = mask_acc;
          timer_d = '0;
          state_d = StCollect;
        end
      end
      StCollect: begin
        mask_d  = mask_acc;
        timer_d = timer_q + 16'd1;
        if ((mask_acc == 3'b111) || dup || (timer_q == TimerLast)) state_d = close_state;
      end
      StVote: begin
        if (mask_q[0])      rd_len_d = len_q[0];
        else if (mask_q[1]) rd_len_d = len_q[1];
        else                rd_len_d = len_q[2];
        rd_addr_d = '0;
        state_d   = StRead;
      end
      StRead: begin
        if (rd_en_q && bus.rd_ready) begin
          if (rd_addr_q == rd_len_q) begin
            mask_d  = '0;
            state_d = StIdle;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
      end
      StDrop: begin
        lost_d  = 1'b1;
        mask_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      mask_q       <= '0;
      timer_q      <= '0;
      len_q        <= '0;
      rd_len_q     <= '0;
      rd_addr_q    <= '0;
      vote_start_q <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_last_q    <= 1'b0;
      busy_q       <= 1'b0;
      lost_q       <= 1'b0;
      copy_mask_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      timer_q      <= timer_d;
      len_q        <= len_acc;
      rd_len_q     <= rd_len_d;
      rd_addr_q    <= rd_addr_d;
      vote_start_q <= (state_d == StVote);
      rd_en_q      <= (state_d == StRead);
      rd_last_q    <= (state_d == StRead) && (rd_addr_d == rd_len_d);
      busy_q       <= (state_d != StIdle);
      lost_q       <= lost_d;
      copy_mask_q  <= ((state_d == StVote) || (state_d == StRead)) ? mask_d : 3'b000;
      if (lost_d && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign bus.vote_start = vote_start_q;
  assign bus.copy_mask  = copy_mask_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_last    = rd_last_q;
  assign bus.busy       = busy_q;
  assign bus.lost       = lost_q;
  assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: doc/vote_sequencer.md
VOTE_SEQUENCER -- requirements
Module: vote_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16'd50000, gives the cycles allowed from the first copy's frame_done to group close.
REQ-002 Parameter AW, default 12, gives the slot address width.
REQ-003 Port clk  in  1  single clock; all logic is on its rising edge.
REQ-004 Port rst  in  1  asynchronous, active-low reset.
REQ-005 Port frame_done  in  1  one-cycle pulse: one copy has finished writing its BRAM slot.
REQ-006 Port frame_id  in  2  copy number of that frame; 1..3 are valid, 0 is ignored.
REQ-007 Port frame_len  in  AW  last written address of that copy; sampled with frame_done.
REQ-008 Port vote_start  out  1  one-cycle pulse that launches the comparator/readout path.
REQ-009 Port copy_mask  out  3  copies present in the group (bit0 = id1); held from vote_start until READ ends.
REQ-010 Port rd_ready  in  1  downstream accepts the current read beat.
REQ-011 Port rd_en, rd_addr, rd_last  out  1, AW, 1  read beat valid, slot B-port address, final beat flag.
REQ-012 Port busy  out  1  high when state is not IDLE.
REQ-013 Port lost  out  1  one-cycle pulse on a dropped group or an ignored frame.
REQ-014 Port drop_cnt  out  8  saturating count of lost pulses.

Function
REQ-015 States: IDLE, COLLECT, VOTE, READ, DROP; encoding is free.
REQ-016 IDLE: frame_done with a valid id sets mask[id-1], stores len[id], clears the timer, and moves to COLLECT.
REQ-017 COLLECT, new id: sets its mask bit and stores its length; when the mask reaches 3'b111 (including by this frame), move to VOTE on the next cycle.
REQ-018 COLLECT, duplicate id (bit already set): frame ignored, lost pulses, and the group closes as on timeout.
REQ-019 COLLECT timer: increments every cycle; at timer == TIMEOUT-1 the group closes.
REQ-020 Group close: popcount(mask) >= 2 -> VOTE; popcount(mask) < 2 -> DROP.
REQ-021 VOTE: vote_start = 1 for exactly one cycle; rd_len = stored length of the lowest-numbered present copy; next state READ.
REQ-022 READ: rd_en = 1 and rd_addr starts at 0; rd_addr increments only on rd_en && rd_ready; it holds while rd_ready = 0.
REQ-023 rd_last = rd_en && (rd_addr == rd_len); an accepted last beat moves to IDLE and clears mask.
REQ-024 rd_len = 0 gives a single beat; the address never wraps past rd_len.
REQ-025 DROP: lost = 1 for one cycle, mask cleared, next state IDLE.
REQ-026 frame_done in VOTE, READ or DROP: frame ignored, lost pulses.
REQ-027 A lost request in the same cycle as the DROP pulse produces one pulse only; drop_cnt increments by 1.
REQ-028 frame_done with frame_id = 0: ignored in every state, no lost pulse.
REQ-029 drop_cnt increments once per lost pulse and saturates at 8'hFF.
REQ-030 Outputs are registered; rd_addr/rd_en change one cycle after the accepting edge.

Reset
REQ-031 rst low forces, asynchronously: state = IDLE, mask, timer, len registers and rd_addr = 0.
REQ-032 rst low also forces vote_start, rd_en, rd_last, busy, lost = 0 and drop_cnt = 0.
REQ-033 Reset asserted mid-READ or mid-COLLECT abandons the group with no lost pulse.
REQ-034 After rst deasserts, the first valid frame_done is accepted in the same cycle.

Configuration
REQ-035 Macro VOTE_SEQ_LEN_CHECK_EN, when defined: at group close, present copies whose stored lengths differ -> DROP (lost) instead of VOTE.
REQ-036 VOTE_SEQ_LEN_CHECK_EN undefined: no length comparison; REQ-021 length selection applies.

Verification
REQ-037 Ids 1, 2, 3 with len 100, then rd_ready = 1 -> one vote_start, copy_mask = 3'b111, 101 beats at addr 0..100, rd_last on addr 100, lost never pulses.
REQ-038 Ids 2, 3 only (len 60), TIMEOUT = 200 -> vote_start 200 cycles after id 2, copy_mask = 3'b110, rd_len = 60.
REQ-039 Id 1 only, timeout -> DROP, one lost pulse, drop_cnt = 1, no vote_start.
REQ-040 Ids 1, 1 -> second frame ignored, lost pulses, group closes with popcount 1 -> DROP; drop_cnt = 2.
REQ-041 READ with rd_ready toggling 1,0,0,1 -> rd_addr holds during the low cycles; no beat is skipped or repeated.
REQ-042 VOTE_SEQ_LEN_CHECK_EN defined, ids 1, 2, 3 with lens 100, 100, 99 -> DROP, lost pulses; undefined -> vote with rd_len = 100.
